// File: rtl/reaction_timer_rounds.sv
// Multi-round reaction timer: random pre-stimulus delay, per-round reaction time
// in ms, session best and truncated average, false-start and timeout detection.
module reaction_timer_rounds #(
  parameter int unsigned MS_TICKS     = 100000,
  parameter int unsigned MIN_DELAY_MS = 2000,
  parameter int unsigned RAND_W       = 10,
  parameter int unsigned TIMEOUT_MS   = 1000,
  parameter int unsigned ROUNDS       = 4,
  parameter int unsigned RESULT_W     = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [RAND_W-1:0]   rand_in,
  output logic                led,
  output logic [RESULT_W-1:0] result_ms,
  output logic [RESULT_W-1:0] best_ms,
  output logic [4:0]          round_idx,
  output logic [2:0]          status,
  output logic                result_valid
);

  localparam int unsigned PRESC_W = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam int unsigned SUM_W   = RESULT_W + 4;
  localparam int unsigned AVG_SH  = (ROUNDS > 1) ? $clog2(ROUNDS) : 0;
  localparam int unsigned FALSE_CODE = 9999;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_REACT   = 3'd2,
    S_ROUND   = 3'd3,
    S_AVG     = 3'd4,
    S_FALSE   = 3'd5,
    S_TIMEOUT = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic                  start_s_q, start_p_q, stop_s_q, stop_p_q;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [RESULT_W-1:0]   ms_q, ms_d;
  logic [RESULT_W-1:0]   delay_q, delay_d;
  logic [RESULT_W-1:0]   last_q, last_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [RESULT_W-1:0]   best_q, best_d;
  logic [4:0]            round_q, round_d;
  logic                  led_q, led_d;
  logic [RESULT_W-1:0]   res_q, res_d;
  logic                  valid_q, valid_d;

  logic start_e, stop_e, ms_tick, enter_cnt;
  logic [RESULT_W-1:0] new_delay;

  assign start_e   = start_s_q & ~start_p_q;
  assign stop_e    = stop_s_q & ~stop_p_q;
  assign ms_tick   = (presc_q == PRESC_W'(MS_TICKS - 1));
  assign new_delay = RESULT_W'(MIN_DELAY_MS) + RESULT_W'(rand_in);

  // Next-state, session bookkeeping, ms timebase and registered-output values
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    last_d  = last_q;
    sum_d   = sum_q;
    best_d  = best_q;
    round_d = round_q;
    valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_e) begin
          sum_d   = '0;
          round_d = '0;
          best_d  = '1;
          delay_d = new_delay;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop_e)                state_d = S_FALSE;
        else if (ms_q == delay_q)  state_d = S_REACT;
      end
      S_REACT: begin
        if (stop_e) begin
          last_d  = ms_q;
          sum_d   = sum_q + SUM_W'(ms_q);
          best_d  = (ms_q < best_q) ? ms_q : best_q;
          round_d = round_q + 5'd1;
          valid_d = 1'b1;
          state_d = S_ROUND;
        end else if (ms_q == RESULT_W'(TIMEOUT_MS)) begin
          state_d = S_TIMEOUT;
        end
      end
      S_ROUND: begin
        if (start_e) begin
          if (round_q < 5'(ROUNDS)) begin
            delay_d = new_delay;
            state_d = S_WAIT;
          end else begin
            state_d = S_AVG;
          end
        end
      end
      S_AVG, S_FALSE, S_TIMEOUT: begin
        if (start_e) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Timebase restarts on every entry to WAIT or REACT so the first ms is full length
    enter_cnt = (state_d != state_q) && ((state_d == S_WAIT) || (state_d == S_REACT));
    if (enter_cnt) begin
      presc_d = '0;
      ms_d    = '0;
    end else begin
      presc_d = ms_tick ? '0 : presc_q + 1'b1;
      ms_d    = (ms_tick && (ms_q != '1)) ? ms_q + 1'b1 : ms_q;
    end

    led_d = (state_d == S_REACT);
    unique case (state_d)
      S_REACT:   res_d = ms_d;
      S_ROUND:   res_d = last_d;
      S_AVG:     res_d = RESULT_W'(sum_d >> AVG_SH);
      S_FALSE:   res_d = RESULT_W'(FALSE_CODE);
      S_TIMEOUT: res_d = RESULT_W'(TIMEOUT_MS);
      default:   res_d = '0;
    endcase
  end

  // State and datapath registers; button sync resets to "pressed" so a held button cannot fire
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      start_s_q <= 1'b1;
      start_p_q <= 1'b1;
      stop_s_q  <= 1'b1;
      stop_p_q  <= 1'b1;
      presc_q   <= '0;
      ms_q      <= '0;
      delay_q   <= '0;
      last_q    <= '0;
      sum_q     <= '0;
      best_q    <= '1;
      round_q   <= '0;
      led_q     <= 1'b0;
      res_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_s_q <= start;
      start_p_q <= start_s_q;
      stop_s_q  <= stop;
      stop_p_q  <= stop_s_q;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      delay_q   <= delay_d;
      last_q    <= last_d;
      sum_q     <= sum_d;
      best_q    <= best_d;
      round_q   <= round_d;
      led_q     <= led_d;
      res_q     <= res_d;
      valid_q   <= valid_d;
    end
  end

  assign led          = led_q;
  assign result_ms    = res_q;
  assign best_ms      = best_q;
  assign round_idx    = round_q;
  assign status       = state_q;
  assign result_valid = valid_q;

endmodule
